// File: rtl/karatsuba_recombine.sv
// karatsuba_recombine: folds z0/z1/z2 into the 4N-bit product
// using one shared carry-lookahead add/sub over four passes.
`timescale 1ns/1ps

module karatsuba_cla #(
  parameter int W = 34
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int E = W + 1;

  // Kogge-Stone prefix; cin rides in as an extra generate bit 0
  always_comb begin
    logic [E-1:0] g;
    logic [E-1:0] p;
    logic [E-1:0] gn;
    logic [E-1:0] pn;
    g = {a & b, cin};
    p = {a ^ b, 1'b0};
    gn = g;
    pn = p;
    for (int d = 1; d < E; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < E; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    sum  = (a ^ b) ^ g[W-1:0];
    cout = g[W];
  end

endmodule

module karatsuba_recombine #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] z0,
  input  logic [2*N-1:0] z2,
  input  logic [2*N+1:0] z1,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*N-1:0] product,
  output logic           err
);

  localparam int W = 2 * N + 2;

  typedef enum logic [2:0] {
    IDLE,
    SUB0,
    SUB2,
    ADDLO,
    ADDHI,
    DONE
  } state_t;

  typedef struct packed {
    logic [2*N-1:0] z2;
    logic [2*N+1:0] z1;
    logic [2*N-1:0] z0;
  } ops_t;

  state_t       state;
  ops_t         ops;
  logic [W-1:0] mid;
  logic         c_lo;
  logic         err_acc;

  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic         hi_ovf;

  karatsuba_cla #(.W(W)) u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state)
      SUB0: begin
        add_a   = ops.z1;
        add_b   = ~{2'b00, ops.z0};
        add_cin = 1'b1;
      end
      SUB2: begin
        add_a   = mid;
        add_b   = ~{2'b00, ops.z2};
        add_cin = 1'b1;
      end
      ADDLO: begin
        add_a = {2'b00, ops.z2[N-1:0], ops.z0[2*N-1:N]};
        add_b = {2'b00, mid[2*N-1:0]};
      end
      ADDHI: begin
        add_a   = {{(N+2){1'b0}}, ops.z2[2*N-1:N]};
        add_b   = {{(2*N+1){1'b0}}, mid[2*N]};
        add_cin = c_lo;
      end
      default: begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
      end
    endcase
  end

  assign hi_ovf = |add_sum[W-1:N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ops       <= '0;
      mid       <= '0;
      c_lo      <= 1'b0;
      err_acc   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      product   <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ops.z0   <= z0;
            ops.z1   <= z1;
            ops.z2   <= z2;
            err_acc  <= 1'b0;
            in_ready <= 1'b0;
            state    <= SUB0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SUB0: begin
          mid <= add_sum;
          if (!add_cout) err_acc <= 1'b1;
          state <= SUB2;
        end
        SUB2: begin
          mid <= add_sum;
          if (!add_cout || add_sum[W-1]) err_acc <= 1'b1;
          state <= ADDLO;
        end
        ADDLO: begin
          product[3*N-1:N] <= add_sum[2*N-1:0];
          product[N-1:0]   <= ops.z0[N-1:0];
          c_lo             <= add_sum[2*N];
          state            <= ADDHI;
        end
        ADDHI: begin
          product[4*N-1:3*N] <= add_sum[N-1:0];
          err_acc            <= err_acc | hi_ovf;
          err                <= err_acc | hi_ovf;
          out_valid          <= 1'b1;
          state              <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
